nanov_spi_mem: RTL and testbench



---
 rtl/nanov_spi_mem.sv | 146 ++++++++++++++
 tb/tb_nanov_spi_mem.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nanov_spi_mem.sv
// nanov_spi_mem: SPI memory responder clocked by the nanoV CPU clock.
// Define SPI_MEM_WRITE_EN to accept WRITE_CMD; otherwise memory loads only via backdoor.
module nanov_spi_mem #(
  parameter int         ADDR_BITS = 10,
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 spi_select,
  input  logic                 spi_clk_enable,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [7:0]           load_data,
  output logic                 active
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CMD    = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] READ   = 3'd3;
  localparam logic [2:0] IGNORE = 3'd5;
`ifdef SPI_MEM_WRITE_EN
  localparam logic [2:0] WRITE  = 3'd4;
`endif

  logic [7:0]           mem [2**ADDR_BITS];
  logic [2:0]           state;
  logic [4:0]           bit_cnt;
  logic [6:0]           shift;
  logic [ADDR_BITS-1:0] addr;
`ifdef SPI_MEM_WRITE_EN
  logic                 wr_mode;
`endif

  logic                 bit_ev;
  logic [7:0]           cmd;
  logic [ADDR_BITS-1:0] addr_nxt;
  logic [ADDR_BITS-1:0] addr_inc;
  logic [2:0]           rd_idx;

  assign bit_ev   = !spi_select && spi_clk_enable;
  assign cmd      = {shift, spi_mosi};
  assign addr_nxt = {addr[ADDR_BITS-2:0], spi_mosi};
  assign addr_inc = addr + ADDR_BITS'(1);
  assign rd_idx   = bit_cnt[2:0] - 3'd1;

  always_ff @(posedge clk) begin
    if (!rstn || spi_select) begin
      state    <= IDLE;
      active   <= 1'b0;
      spi_miso <= 1'b0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else if (bit_ev) begin
      shift <= cmd[6:0];
      unique case (state)
        IDLE: begin
          state   <= CMD;
          active  <= 1'b1;
          bit_cnt <= 5'd1;
        end
        CMD: begin
          if (bit_cnt == 5'd7) begin
            bit_cnt <= '0;
            case (cmd)
              READ_CMD: begin
                state <= ADDR;
`ifdef SPI_MEM_WRITE_EN
                wr_mode <= 1'b0;
`endif
              end
              WRITE_CMD: begin
`ifdef SPI_MEM_WRITE_EN
                state   <= ADDR;
                wr_mode <= 1'b1;
`else
                state   <= IGNORE;
`endif
              end
              default: state <= IGNORE;
            endcase
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        ADDR: begin
          addr <= addr_nxt;
          if (bit_cnt == 5'd23) begin
`ifdef SPI_MEM_WRITE_EN
            if (wr_mode) begin
              state   <= WRITE;
              bit_cnt <= '0;
            end else begin
              state    <= READ;
              spi_miso <= mem[addr_nxt][7];
              bit_cnt  <= 5'd7;
            end
`else
            state    <= READ;
            spi_miso <= mem[addr_nxt][7];
            bit_cnt  <= 5'd7;
`endif
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        // bit_cnt holds the index of the bit currently on spi_miso
        READ: begin
          if (bit_cnt == 5'd0) begin
            addr     <= addr_inc;
            spi_miso <= mem[addr_inc][7];
            bit_cnt  <= 5'd7;
          end else begin
            spi_miso <= mem[addr][rd_idx];
            bit_cnt  <= bit_cnt - 5'd1;
          end
        end
`ifdef SPI_MEM_WRITE_EN
        WRITE: begin
          if (bit_cnt == 5'd7) begin
            addr    <= addr_inc;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Backdoor is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
`ifdef SPI_MEM_WRITE_EN
    if (rstn && bit_ev && state == WRITE && bit_cnt == 5'd7)
      mem[addr] <= cmd;
`endif
    if (load_en)
      mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_nanov_spi_mem.sv
// tb_nanov_spi_mem: randomized checks of nanov_spi_mem against a byte-array model.
// Write expectations follow SPI_MEM_WRITE_EN when the bench is built with it.
module tb_nanov_spi_mem;
  localparam int AB  = 10;
  localparam int MSZ = 1 << AB;
  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          spi_select = 1'b1;
  logic          spi_clk_enable = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic          load_en = 1'b0;
  logic [AB-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic          active;

  logic [7:0] model [MSZ];
  logic       rx[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  nanov_spi_mem #(.ADDR_BITS(AB)) dut (
    .clk(clk),
    .rstn(rstn),
    .spi_select(spi_select),
    .spi_clk_enable(spi_clk_enable),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .active(active)
  );

  task automatic cyc(input logic sel, input logic en, input logic mosi);
    @(negedge clk);
    spi_select = sel;
    spi_clk_enable = en;
    spi_mosi = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic deselect();
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input int a, input logic [7:0] d);
    @(negedge clk);
    spi_select = 1'b1;
    spi_clk_enable = 1'b0;
    load_en = 1'b1;
    load_addr = AB'(a);
    load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    model[a % MSZ] = d;
  endtask

  task automatic send(input bq_t b, input int nbits, input bit gap);
    logic prev;
    int n;
    n = 0;
    for (int i = 0; i < b.size(); i++) begin
      for (int k = 7; k >= 0; k--) begin
        if (n < nbits) begin
          if (gap) begin
            prev = spi_miso;
            cyc(1'b0, 1'b0, b[i][k]);
            checks++;
            if (spi_miso !== prev) begin
              errors++;
              $display("FAIL gap_hold bit%0d got %b exp %b", n, spi_miso, prev);
            end
          end
          cyc(1'b0, 1'b1, b[i][k]);
          rx.push_back(spi_miso);
          n++;
        end
      end
    end
  endtask

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] v;
    for (int j = 0; j < 8; j++)
      v[7-j] = rx[31 + 8*k + j];
    return v;
  endfunction

  task automatic read_check(input string name, input int a, input int n, input bit gap);
    bq_t q;
    logic [7:0] got;
    logic [7:0] exp;
    q = {8'h03, 8'(a >> 16), 8'(a >> 8), 8'(a)};
    for (int i = 0; i < n; i++) q.push_back(8'h00);
    rx.delete();
    send(q, 32 + 8*n, gap);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL %s_active got %b exp 1", name, active);
    end
    deselect();
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got %b exp 0", name, active);
    end
    for (int k = 0; k < n; k++) begin
      got = rx_byte(k);
      exp = model[(a + k) % MSZ];
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s byte%0d got %02h exp %02h", name, k, got, exp);
      end
    end
  endtask

  task automatic check_rx_zero(input string name);
    int ones;
    ones = 0;
    foreach (rx[i]) if (rx[i] !== 1'b0) ones++;
    checks++;
    if (ones != 0) begin
      errors++;
      $display("FAIL %s miso_nonzero_bits got %0d exp 0", name, ones);
    end
  endtask

  task automatic test_reset();
    load(0, 8'hA5);
    @(negedge clk);
    rstn = 1'b0;
    spi_select = 1'b0;
    spi_clk_enable = 1'b1;
    spi_mosi = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL reset_miso got %b exp 0", spi_miso);
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL reset_active got %b exp 0", active);
    end
    @(negedge clk);
    rstn = 1'b1;
    deselect();
    read_check("reset_keep", 0, 1, 1'b0);
  endtask

  task automatic test_read();
    load(16'h010, 8'h13);
    load(16'h011, 8'h05);
    load(16'h012, 8'h00);
    load(16'h013, 8'h00);
    read_check("cont_read", 16'h010, 4, 1'b0);
  endtask

  task automatic test_gap_wrap();
    load(16'h3FF, 8'hC3);
    load(16'h000, 8'h5A);
    read_check("gap_wrap", 16'h3FF, 2, 1'b1);
  endtask

  task automatic test_write();
    for (int i = 0; i < 3; i++) load(16'h020 + i, 8'($urandom));
    rx.delete();
    send({8'h02, 8'h00, 8'h00, 8'h20, 8'hAB, 8'hCD, 8'hF0}, 52, 1'b0);
    check_rx_zero("write_miso");
    deselect();
`ifdef SPI_MEM_WRITE_EN
    model[16'h020] = 8'hAB;
    model[16'h021] = 8'hCD;
`endif
    read_check("write_rb", 16'h020, 3, 1'b0);
  endtask

  task automatic test_abort();
    bq_t q;
    rx.delete();
    send({8'h03, 8'h00, 8'h00}, 20, 1'b0);
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL abort_mid_active got %b exp 1", active);
    end
    deselect();
    checks++;
    if (active !== 1'b0 || spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got active=%b miso=%b exp 0 0", active, spi_miso);
    end
    load(0, 8'($urandom));
    read_check("abort_new", 0, 1, 1'b0);
    q = {8'h9F};
    for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
    rx.delete();
    send(q, 48, 1'b0);
    check_rx_zero("unknown_op");
    checks++;
    if (active !== 1'b1) begin
      errors++;
      $display("FAIL unknown_active got %b exp 1", active);
    end
    deselect();
  endtask

  task automatic test_random();
    int a;
    int n;
    bit gap;
    for (int it = 0; it < 8; it++) begin
      a = int'($urandom & 32'h00FF_FFFF);
      n = int'($urandom_range(1, 4));
      gap = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) load(a + k, 8'($urandom));
      read_check("rand_read", a, n, gap);
    end
  endtask

  task automatic test_back_to_back();
    int a;
    a = int'($urandom_range(0, MSZ - 3));
    for (int k = 0; k < 3; k++) load(a + k, 8'($urandom));
    read_check("b2b_first", a, 2, 1'b0);
    read_check("b2b_second", a + 1, 2, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MSZ; i++) model[i] = 8'h00;
    for (int i = 0; i < MSZ; i++) load(i, 8'h00);
    test_reset();
    test_read();
    test_gap_wrap();
    test_write();
    test_abort();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
